uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed data word on the receiver's one-cycle data_ready pulse and holds it until the consumer (game-control logic) pops it. It is a circular-buffer FIFO with show-ahead read data, full/empty/count status, and a sticky overflow flag for words dropped while full.

---
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular-buffer FIFO downstream of the UART receiver.
// Captures each data_ready word and holds it until the consumer pops it.
// Ports:
//   clk_100MHz   - system clock, rising edge
//   reset        - synchronous active-high reset
//   wr_en        - write strobe (receiver data_ready pulse)
//   wr_data      - word to store (receiver data_out)
//   rd_en        - pop request; ignored while empty
//   clr_overflow - clears the sticky overflow flag
//   rd_data      - show-ahead head word, valid while empty=0
//   empty/full   - registered status flags
//   count        - stored words, 0..2**ADDR_WIDTH
//   overflow     - sticky, set when a write is dropped while full
module uart_rx_fifo #(
    parameter int DBITS      = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DBITS-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic                  clr_overflow,
    output logic [DBITS-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ALMOST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH + 1)'(1);

    logic [DBITS-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    // A write into a full FIFO is only accepted when a pop frees the head
    // slot in the same cycle.
    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || do_rd);
    end

    assign rd_data = mem[rd_ptr];

    // Storage is deliberately not reset.
    always_ff @(posedge clk_100MHz) begin
        if (!reset && do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10: begin
                    count <= count + 1'b1;
                    empty <= 1'b0;
                    full  <= (count == CNT_ALMOST);
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == CNT_ONE);
                end
                default: begin
                end
            endcase
            // Setting wins over clearing when both happen together.
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int tests_run = 0;
    int failed = 0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;

    uart_rx_fifo #(.DBITS(8), .ADDR_WIDTH(2)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .clr_overflow(clr_overflow),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Drive one cycle, update the model from pre-edge state, sample at +1.
    task automatic tick(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rst);
        bit was_full;
        bit popping;
        wr_en = w;
        wr_data = d;
        rd_en = r;
        clr_overflow = c;
        reset = rst;
        @(posedge clk_100MHz);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            popping = r && (q.size() > 0);
            if (w && was_full && !r) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (popping) void'(q.pop_front());
            if (w && (!was_full || popping)) q.push_back(d);
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_overflow = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (empty !== 1'b1) begin
            failed++; $display("FAIL reset_empty: got %b exp 1", empty);
        end
        tests_run++;
        if (full !== 1'b0) begin
            failed++; $display("FAIL reset_full: got %b exp 0", full);
        end
        tests_run++;
        if (count !== 3'd0) begin
            failed++; $display("FAIL reset_count: got %0d exp 0", count);
        end
        tests_run++;
        if (overflow !== 1'b0) begin
            failed++; $display("FAIL reset_ovf: got %b exp 0", overflow);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            tests_run++;
            if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
                failed++;
                $display("FAIL idle_pop: got cnt=%0d emp=%b ovf=%b exp 0/1/0",
                         count, empty, overflow);
            end
        end
    endtask

    task automatic test_single();
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (empty !== 1'b0 || count !== 3'd1 || rd_data !== 8'hA5) begin
            failed++;
            $display("FAIL single_wr: got emp=%b cnt=%0d rd=%h exp 0/1/a5",
                     empty, count, rd_data);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            failed++;
            $display("FAIL single_rd: got emp=%b cnt=%0d exp 1/0", empty, count);
        end
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (full !== 1'b1 || count !== 3'd4) begin
            failed++;
            $display("FAIL fill: got full=%b cnt=%0d exp 1/4", full, count);
        end
        for (int i = 1; i <= 2; i++) begin
            exp = 8'(i);
            tests_run++;
            if (rd_data !== exp) begin
                failed++; $display("FAIL fill_pop: got %h exp %h", rd_data, exp);
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i <= 6; i++) begin
            exp = 8'(i);
            tests_run++;
            if (rd_data !== exp || empty !== 1'b0) begin
                failed++;
                $display("FAIL wrap_pop: got %h emp=%b exp %h", rd_data, empty, exp);
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            failed++;
            $display("FAIL wrap_empty: got emp=%b cnt=%0d exp 1/0", empty, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            failed++;
            $display("FAIL ovf_set: got ovf=%b cnt=%0d full=%b exp 1/4/1",
                     overflow, count, full);
        end
        tests_run++;
        if (rd_data !== 8'h10) begin
            failed++; $display("FAIL ovf_head: got %h exp 10", rd_data);
        end
    endtask

    task automatic test_overflow_clear();
        logic [7:0] exp;
        tick(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (overflow !== 1'b1) begin
            failed++; $display("FAIL ovf_prio: got %b exp 1", overflow);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (overflow !== 1'b0) begin
            failed++; $display("FAIL ovf_clr: got %b exp 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            tests_run++;
            if (rd_data !== exp || empty !== 1'b0) begin
                failed++;
                $display("FAIL ovf_drain: got %h emp=%b exp %h", rd_data, empty, exp);
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tests_run++;
        if (empty !== 1'b1) begin
            failed++; $display("FAIL ovf_empty: got %b exp 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        tick(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (count !== 3'd1 || empty !== 1'b0 || rd_data !== 8'h3C) begin
            failed++;
            $display("FAIL sim_empty: got cnt=%0d emp=%b rd=%h exp 1/0/3c",
                     count, empty, rd_data);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h24, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL sim_full: got cnt=%0d full=%b ovf=%b exp 4/1/0",
                     count, full, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'h20 + 8'(i);
            tests_run++;
            if (rd_data !== exp) begin
                failed++; $display("FAIL sim_drain: got %h exp %h", rd_data, exp);
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (count !== 3'd2) begin
            failed++; $display("FAIL mid_fill: got %0d exp 2", count);
        end
        tick(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset: got cnt=%0d emp=%b full=%b exp 0/1/0",
                     count, empty, full);
        end
    endtask

    task automatic test_random();
        logic w, r, c, rst;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 10);
            rst = ($urandom_range(0, 99) < 2);
            d = 8'($urandom);
            tick(w, d, r, c, rst);
            tests_run++;
            if (count !== 3'(q.size()) || empty !== (q.size() == 0) ||
                full !== (q.size() == DEPTH) || overflow !== m_ovf) begin
                failed++;
                $display("FAIL rnd_status[%0d]: got cnt=%0d emp=%b full=%b ovf=%b exp cnt=%0d ovf=%b",
                         n, count, empty, full, overflow, q.size(), m_ovf);
            end
            if (q.size() > 0) begin
                tests_run++;
                if (rd_data !== q[0]) begin
                    failed++;
                    $display("FAIL rnd_data[%0d]: got %h exp %h", n, rd_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_fill_wrap();
        test_overflow();
        test_overflow_clear();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
